// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - valid/ready instruction and result bus of the immediate generator
interface imm_gen_pipe_if #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
);
   logic              i_valid;
   logic              o_ready;
   logic [31:0]       i_inst;
   logic [DATA_W-1:0] i_pc;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_imm;
   logic [DATA_W-1:0] o_target;
   logic [2:0]        o_fmt;
   logic              i_cnt_clr;
   logic [CNT_W-1:0]  o_illegal_cnt;

   // generator side: consumes instructions, produces decoded beats
   modport slave (
      input  i_valid, i_inst, i_pc, i_ready, i_cnt_clr,
      output o_ready, o_valid, o_imm, o_target, o_fmt, o_illegal_cnt
   );

   // fetch/execute side: drives instructions, takes decoded beats
   modport master (
      output i_valid, i_inst, i_pc, i_ready, i_cnt_clr,
      input  o_ready, o_valid, o_imm, o_target, o_fmt, o_illegal_cnt
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV64I immediate generator with two-entry output buffer
module imm_gen_pipe #(
   parameter int DATA_W   = 64,
   parameter int SIGN_EXT = 1,
   parameter int CNT_W    = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   imm_gen_pipe_if.slave bus
);
   localparam logic [2:0] FMT_R     = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_ILL   = 3'd7;

   logic [31:0]       inst;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              is_shift;
   logic              fill;
   logic [63:0]       dec_wide;
   logic [2:0]        dec_fmt;
   logic [DATA_W-1:0] dec_imm;
   logic [DATA_W-1:0] dec_target;

   logic              out_valid;
   logic [DATA_W-1:0] out_imm;
   logic [DATA_W-1:0] out_target;
   logic [2:0]        out_fmt;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_imm;
   logic [DATA_W-1:0] skid_target;
   logic [2:0]        skid_fmt;
   logic [CNT_W-1:0]  illegal_cnt;

   logic              accept;
   logic              drain;

   assign inst     = bus.i_inst;
   assign opcode   = inst[6:0];
   assign funct3   = inst[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   // every non-shift format takes its sign from inst[31]; zero-extension forces the fill low
   assign fill = (SIGN_EXT != 0) && inst[31];

   // opcode decode: build the immediate at full 64-bit width, then trim to DATA_W
   always_comb begin
      dec_wide = 64'd0;
      dec_fmt  = FMT_ILL;
      case (opcode)
         7'b0000011, 7'b1100111: begin
            dec_fmt  = FMT_I;
            dec_wide = {{52{fill}}, inst[31:20]};
         end
         7'b0010011: begin
            if (is_shift) begin
               dec_fmt  = FMT_SHAMT;
               dec_wide = {58'd0, inst[25:20]};
            end else begin
               dec_fmt  = FMT_I;
               dec_wide = {{52{fill}}, inst[31:20]};
            end
         end
         7'b0011011: begin
            // word shifts carry a 5-bit shamt; bit 25 belongs to funct7 here
            if (is_shift) begin
               dec_fmt  = FMT_SHAMT;
               dec_wide = {59'd0, inst[24:20]};
            end else begin
               dec_fmt  = FMT_I;
               dec_wide = {{52{fill}}, inst[31:20]};
            end
         end
         7'b0100011: begin
            dec_fmt  = FMT_S;
            dec_wide = {{52{fill}}, inst[31:25], inst[11:7]};
         end
         7'b1100011: begin
            dec_fmt  = FMT_B;
            dec_wide = {{51{fill}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt  = FMT_U;
            dec_wide = {{32{fill}}, inst[31:12], 12'd0};
         end
         7'b1101111: begin
            dec_fmt  = FMT_J;
            dec_wide = {{43{fill}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         7'b0110011, 7'b0111011: begin
            dec_fmt  = FMT_R;
            dec_wide = 64'd0;
         end
         default: begin
            dec_fmt  = FMT_ILL;
            dec_wide = 64'd0;
         end
      endcase
   end

   // with DATA_W=32 the low word of the U immediate is the unextended value
   assign dec_imm    = dec_wide[DATA_W-1:0];
   assign dec_target = bus.i_pc + dec_imm;

   // o_ready depends only on the skid flop, so i_ready never reaches it combinationally
   assign accept = bus.i_valid && !skid_valid;
   assign drain  = out_valid && bus.i_ready;

   // two-entry buffer: OUT feeds the consumer, SKID absorbs one beat of back-pressure
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_valid   <= 1'b0;
         out_imm     <= '0;
         out_target  <= '0;
         out_fmt     <= FMT_R;
         skid_valid  <= 1'b0;
         skid_imm    <= '0;
         skid_target <= '0;
         skid_fmt    <= FMT_R;
      end else if (drain) begin
         if (skid_valid) begin
            out_imm    <= skid_imm;
            out_target <= skid_target;
            out_fmt    <= skid_fmt;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_imm    <= dec_imm;
            out_target <= dec_target;
            out_fmt    <= dec_fmt;
         end else begin
            out_valid  <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid) begin
            out_valid  <= 1'b1;
            out_imm    <= dec_imm;
            out_target <= dec_target;
            out_fmt    <= dec_fmt;
         end else begin
            skid_valid  <= 1'b1;
            skid_imm    <= dec_imm;
            skid_target <= dec_target;
            skid_fmt    <= dec_fmt;
         end
      end
   end

   // saturating count of accepted illegal opcodes; clear wins over a same-cycle increment
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         illegal_cnt <= '0;
      end else if (bus.i_cnt_clr) begin
         illegal_cnt <= '0;
      end else if (accept && (dec_fmt == FMT_ILL) && (illegal_cnt != {CNT_W{1'b1}})) begin
         illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

   assign bus.o_ready       = !skid_valid;
   assign bus.o_valid       = out_valid;
   assign bus.o_imm         = out_imm;
   assign bus.o_target      = out_target;
   assign bus.o_fmt         = out_fmt;
   assign bus.o_illegal_cnt = illegal_cnt;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RV64I immediate generator for the CPU decode stage. It extracts and sign-extends the immediate for every base format (I, S, B, U, J, plus shift-amount forms), classifies the instruction format, and precomputes the PC-relative target. It sits between fetch and execute behind a valid/ready handshake, with a two-entry output buffer so back-pressure never drops an instruction. A saturating counter records accepted illegal opcodes for debug.

## Interface
- DATA_W, 64, immediate/PC/target width; legal values 32 or 64.
- SIGN_EXT, 1, 1 = sign-extend immediates to DATA_W; 0 = zero-extend. Shift amounts are always zero-extended.
- CNT_W, 16, illegal-opcode counter width.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  block can accept this cycle.
- i_inst  in  32  instruction word.
- i_pc  in  DATA_W  PC of i_inst.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts output beat.
- o_imm  out  DATA_W  extended immediate.
- o_target  out  DATA_W  i_pc + o_imm, modulo 2^DATA_W.
- o_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 illegal.
- i_cnt_clr  in  1  synchronous clear of illegal counter.
- o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Accept = i_valid && o_ready at a rising edge; accepted beat captures i_inst, i_pc.
- Decode by opcode i_inst[6:0]:
  - 0000011, 0010011 (funct3 not 001/101), 0011011 (funct3 not 001/101), 1100111: I, imm = inst[31:20].
  - 0010011 funct3 001/101: SHAMT, imm = inst[25:20]. 0011011 funct3 001/101: SHAMT, imm = inst[24:20]. Zero-extended.
  - 0100011: S, imm = {inst[31:25], inst[11:7]}.
  - 1100011: B, imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 0110111, 0010111: U, imm = {inst[31:12], 12'b0}.
  - 1101111: J, imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 0110011, 0111011: R, imm = 0.
  - Anything else: illegal, imm = 0, fmt 7.
- Extension from the format's top bit per SIGN_EXT; with DATA_W=32, U imm is used unextended.
- o_target computed for every format; consumers use it only for B, J, U(AUIPC).
- Counter: accepted illegal beat increments by 1, saturating at all-ones; i_cnt_clr has priority over a same-cycle increment (result 0).
- Buffer: output register (OUT) plus skid register (SKID), FIFO order preserved.
  - Output handshake completes when o_valid && i_ready.
  - Accept when OUT empty, or OUT draining this cycle with SKID empty: beat goes to OUT.
  - Accept while OUT full and not draining: beat goes to SKID.
  - OUT draining with SKID full: SKID moves to OUT; SKID frees.
  - o_ready = SKID empty (registered, no combinational path from i_ready).

## Timing
- Reset values: o_valid 0, o_ready 1, o_imm 0, o_target 0, o_fmt 0, o_illegal_cnt 0; both buffer entries empty.
- Latency: accept at edge N, o_valid/o_imm/o_target/o_fmt valid after edge N (visible in cycle N+1).
- Throughput: one beat per cycle while i_ready held 1.
- With i_ready held 0: two beats accepted, o_ready falls after the second accept; no beat lost or duplicated.
- o_valid and the outputs stay stable while o_valid && !i_ready.
- i_rst asserted mid-stream: both entries emptied immediately; in-flight beats discarded; counter cleared.

## Test plan
- Reset, then i_inst=0xFFF00093 (addi x1,x0,-1), i_pc=0x1000, i_ready=1 -> next cycle o_imm=0xFFFF_FFFF_FFFF_FFFF, o_fmt=1, o_target=0xFFF.
- i_inst=0xFE20BC23 (sd x2,-8(x1)) -> o_imm=0xFFFF_FFFF_FFFF_FFF8, o_fmt=2; i_inst=0xFE000EE3 (beq -4), i_pc=0x1000 -> o_imm=-4, o_fmt=3, o_target=0xFFC.
- i_inst=0x800000B7 (lui) -> o_imm=0xFFFF_FFFF_8000_0000, fmt 4; with SIGN_EXT=0 -> 0x0000_0000_8000_0000; i_inst=0x03F0D093 (srli x1,x1,63) -> o_imm=63, fmt 6.
- i_ready=0, stream A,B,C -> A,B accepted, o_ready=0 while C held; i_ready=1 -> A,B,C emerge in order, one per cycle.
- Three beats of i_inst=0x00000000 -> o_fmt=7, o_illegal_cnt=3; i_cnt_clr plus illegal beat in same cycle -> counter 0; CNT_W=2 with five illegal beats -> counter 3.
- Assert i_rst with both entries full -> o_valid=0, o_ready=1 asynchronously; first post-reset beat emerges with latency 1.
